// File: rtl/wb_lfsr_pkg.sv
// Shared types and sizing for the wb_lfsr Wishbone master.
// States, bus widths and parameter defaults live here.
package wb_lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ACK,
        ST_RESP
    } state_e;

    localparam int WB_ADDR_W     = 3;
    localparam int WB_WDATA_W    = 8;
    localparam int WB_RDATA_W    = 1;
    localparam int READ_BITS_DEF = 8;
    localparam int TIMEOUT_DEF   = 255;

endpackage

// File: rtl/wb_lfsr_master_timeout.sv
// Per-beat ack watchdog: loadable down-counter with an expiry flag.
// Only instantiated when WB_MASTER_TIMEOUT_EN is defined.
module wb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [W-1:0] cnt_q;

    // Loaded with TIMEOUT-1 so expiry is seen on the TIMEOUT-th busy cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= W'(TIMEOUT - 1);
        end else if (i_run && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign o_expired = i_run && (cnt_q == '0);

endmodule

// File: rtl/wb_lfsr_master.sv
// Wishbone pipelined master turning byte commands into write or packed-read beats.
// Optional ack watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_lfsr_master
    import wb_lfsr_pkg::*;
#(
    parameter int READ_BITS = READ_BITS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [WB_ADDR_W-1:0]  i_cmd_addr,
    input  logic [WB_WDATA_W-1:0] i_cmd_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [7:0]            o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [WB_ADDR_W-1:0]  o_wb_addr,
    output logic [WB_WDATA_W-1:0] o_wb_data,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_ack,
    input  logic [WB_RDATA_W-1:0] i_wb_data
);

    if (READ_BITS < 1 || READ_BITS > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("wb_lfsr_master: READ_BITS must be 1..8, TIMEOUT >= 1");
    end

    localparam logic [2:0] LAST_BEAT = 3'(READ_BITS - 1);

    state_e                state_q, state_d;
    logic                  we_q;
    logic [WB_ADDR_W-1:0]  addr_q;
    logic [WB_WDATA_W-1:0] wdata_q;
    logic [2:0]            count_q;
    logic [7:0]            shift_q;
    logic                  err_q;

    logic accept;
    logic beat_done;
    logic last_beat;
    logic timed_out;
    logic tmo_expired;

    assign last_beat = we_q || (count_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        beat_done   = 1'b0;
        timed_out   = 1'b0;
        o_cmd_ready = 1'b0;
        o_wb_cyc    = 1'b0;
        o_wb_stb    = 1'b0;
        o_rsp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                o_cmd_ready = i_reset_n;
                if (i_cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                if (!i_wb_stall && i_wb_ack) begin
                    beat_done = 1'b1;
                end else if (tmo_expired) begin
                    timed_out = 1'b1;
                end else if (!i_wb_stall) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                o_wb_cyc = 1'b1;
                if (i_wb_ack) begin
                    beat_done = 1'b1;
                end else if (tmo_expired) begin
                    timed_out = 1'b1;
                end
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (beat_done) begin
            state_d = last_beat ? ST_RESP : ST_REQ;
        end
        if (timed_out) begin
            state_d = ST_RESP;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= i_cmd_we;
                addr_q  <= i_cmd_addr;
                wdata_q <= i_cmd_data;
                count_q <= '0;
                shift_q <= '0;
                err_q   <= 1'b0;
            end
            // Read bits land LSB-first, indexed by beat number.
            if (beat_done) begin
                if (!we_q) begin
                    shift_q[count_q] <= i_wb_data[0];
                end
                if (!last_beat) begin
                    count_q <= count_q + 3'd1;
                end
            end
            if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    logic tmo_load;
    logic tmo_run;

    assign tmo_load = (state_d == ST_REQ) && (state_q != ST_REQ || beat_done);
    assign tmo_run  = (state_q == ST_REQ) || (state_q == ST_WAIT_ACK);

    wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (tmo_load),
        .i_run     (tmo_run),
        .o_expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    assign o_rsp_data = shift_q;
    assign o_rsp_err  = err_q;
    assign o_wb_we    = we_q;
    assign o_wb_addr  = addr_q;
    assign o_wb_data  = wdata_q;

endmodule

// File: tb/tb_wb_lfsr_master.sv
// Directed bench for wb_lfsr_master with a next-cycle-ack slave model.
// Define WB_MASTER_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=4).
module tb_wb_lfsr_master;
    import wb_lfsr_pkg::*;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_we;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_data;
    logic       wb_cyc, wb_stb, wb_we;
    logic [2:0] wb_addr;
    logic [7:0] wb_wdata;
    logic       wb_stall, wb_ack;
    logic [0:0] wb_rdata;

    int n_run  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    logic       sl_pend;
    int         sl_beat;
    int         sl_stall_left;
    int         sl_no_ack;
    logic [7:0] sl_bits;
    int         sl_stb_cnt;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    wb_lfsr_master #(
        .READ_BITS (8),
        .TIMEOUT   (TMO)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_data  (cmd_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .o_wb_we     (wb_we),
        .o_wb_addr   (wb_addr),
        .o_wb_data   (wb_wdata),
        .i_wb_stall  (wb_stall),
        .i_wb_ack    (wb_ack),
        .i_wb_data   (wb_rdata)
    );

    // Slave: acks one cycle after an accepted strobe; drives on negedge.
    initial begin
        sl_pend = 0; sl_beat = 0; sl_stall_left = 0;
        sl_no_ack = -1; sl_bits = 8'h00; sl_stb_cnt = 0;
        wb_stall = 0; wb_ack = 0; wb_rdata = 1'b0;
        forever begin
            @(negedge clk);
            wb_stall = (sl_beat == 0 && sl_stall_left > 0 && wb_stb);
            if (wb_stall) sl_stall_left--;
            wb_ack   = sl_pend;
            wb_rdata = sl_pend ? sl_bits[sl_beat[2:0]] : 1'b0;
            if (sl_pend) sl_beat++;
            sl_pend = wb_cyc && wb_stb && !wb_stall && (sl_beat != sl_no_ack);
            if (wb_stb) sl_stb_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic slave_clear(input logic [7:0] bits, input int stall, input int no_ack);
        sl_pend = 0; sl_beat = 0; sl_stb_cnt = 0;
        sl_bits = bits; sl_stall_left = stall; sl_no_ack = no_ack;
    endtask

    task automatic send_cmd(input logic we, input logic [2:0] a, input logic [7:0] d,
                            output int n);
        int k;
        @(negedge clk);
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_data = d;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            n_run++; n_fail++;
            $display("FAIL cmd_accept: ready=%0b required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        n = cyc_n;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int n, output int lat, output int gaps);
        lat = -1; gaps = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = cyc_n - n + 1;
                break;
            end
            if (!wb_cyc) gaps++;
        end
    endtask

    task automatic take_rsp();
        @(negedge clk);
        rsp_ready = 1;
        @(posedge clk);
        #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_run++;
        if ({cmd_ready, wb_cyc, wb_stb, rsp_valid, rsp_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {cmd_ready, wb_cyc, wb_stb, rsp_valid, rsp_err});
        end
        n_run++;
        if ({rsp_data, wb_we, wb_addr, wb_wdata} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0",
                     {rsp_data, wb_we, wb_addr, wb_wdata});
        end
        rst_n = 1;
        @(posedge clk);
        @(negedge clk);
        n_run++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        int n, lat, gaps;
        slave_clear(8'h00, 0, -1);
        send_cmd(1'b1, 3'd3, 8'hA5, n);
        @(negedge clk);
        n_run++;
        if ({wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata} !== {3'b111, 3'd3, 8'hA5}) begin
            n_fail++;
            $display("FAIL write_beat: got %h required %h",
                     {wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata}, {3'b111, 3'd3, 8'hA5});
        end
        wait_rsp(n, lat, gaps);
        n_run++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL write_latency: got %0d required 3", lat);
        end
        n_run++;
        if ({rsp_err, rsp_data} !== 9'h000) begin
            n_fail++;
            $display("FAIL write_rsp: got err=%b data=%h required 0/00", rsp_err, rsp_data);
        end
        n_run++;
        if (sl_stb_cnt !== 1) begin
            n_fail++;
            $display("FAIL write_stb_count: got %0d required 1", sl_stb_cnt);
        end
        take_rsp();
    endtask

    task automatic test_read();
        int n, lat, gaps;
        slave_clear(8'b0100_1101, 0, -1);
        send_cmd(1'b0, 3'd1, 8'hFF, n);
        @(negedge clk);
        n_run++;
        if ({wb_stb, wb_we, wb_addr} !== {2'b10, 3'd1}) begin
            n_fail++;
            $display("FAIL read_beat: got %b required 10001", {wb_stb, wb_we, wb_addr});
        end
        wait_rsp(n, lat, gaps);
        n_run++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL read_latency: got %0d required 17", lat);
        end
        n_run++;
        if (rsp_data !== 8'h4D || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL read_data: got %h err=%b required 4d err=0", rsp_data, rsp_err);
        end
        n_run++;
        if (gaps !== 0 || sl_stb_cnt !== 8) begin
            n_fail++;
            $display("FAIL read_framing: cyc gaps=%0d stb=%0d required 0 and 8",
                     gaps, sl_stb_cnt);
        end
        take_rsp();
    endtask

    task automatic test_stall();
        int n, lat, gaps, bad;
        slave_clear(8'h5A, 3, -1);
        send_cmd(1'b0, 3'd2, 8'h00, n);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_stb !== 1'b1 || wb_addr !== 3'd2) bad++;
        end
        n_run++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d unstable cycles required 0", bad);
        end
        wait_rsp(n, lat, gaps);
        n_run++;
        if (lat !== 20) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d required 20", lat);
        end
        n_run++;
        if (rsp_data !== 8'h5A || sl_stb_cnt !== 11) begin
            n_fail++;
            $display("FAIL stall_data: got %h stb=%0d required 5a and 11",
                     rsp_data, sl_stb_cnt);
        end
        take_rsp();
    endtask

    task automatic test_backpressure();
        int n, lat, gaps, bad;
        slave_clear(8'hC3, 0, -1);
        send_cmd(1'b0, 3'd0, 8'h00, n);
        wait_rsp(n, lat, gaps);
        cmd_valid = 1; cmd_we = 1; cmd_addr = 3'd7; cmd_data = 8'h11;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 8'hC3 || rsp_err !== 1'b0) bad++;
            if (cmd_ready !== 1'b0) bad++;
        end
        cmd_valid = 0;
        n_run++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d violations required 0", bad);
        end
        take_rsp();
    endtask

    task automatic test_back_to_back();
        int n, lat, gaps, h, a;
        slave_clear(8'h00, 0, -1);
        send_cmd(1'b1, 3'd4, 8'h77, n);
        wait_rsp(n, lat, gaps);
        cmd_valid = 1; cmd_we = 1; cmd_addr = 3'd5; cmd_data = 8'h3C;
        rsp_ready = 1;
        @(posedge clk);
        #1;
        h = cyc_n;
        rsp_ready = 0;
        @(negedge clk);
        n_run++;
        if ({wb_stb, cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_after_rsp: stb/ready got %b required 01", {wb_stb, cmd_ready});
        end
        @(posedge clk);
        #1;
        a = cyc_n;
        cmd_valid = 0;
        slave_clear(8'h00, 0, -1);
        @(negedge clk);
        n_run++;
        if ({wb_stb, wb_addr, wb_wdata} !== {1'b1, 3'd5, 8'h3C} || a - h !== 1) begin
            n_fail++;
            $display("FAIL b2b_accept: got %h gap=%0d required %h gap=1",
                     {wb_stb, wb_addr, wb_wdata}, a - h, {1'b1, 3'd5, 8'h3C});
        end
        wait_rsp(a, lat, gaps);
        n_run++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d required 3", lat);
        end
        take_rsp();
    endtask

    task automatic test_reset_mid();
        int n, lat, gaps, k, bad;
        slave_clear(8'hFF, 0, -1);
        send_cmd(1'b0, 3'd4, 8'h00, n);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(sl_beat == 4 && wb_stb) && k < 50);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        n_run++;
        if ({wb_cyc, wb_stb, rsp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_idle: cyc/stb/rsp got %b required 000",
                     {wb_cyc, wb_stb, rsp_valid});
        end
        rst_n = 1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0) bad++;
        end
        n_run++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_rsp: %0d bad cycles required 0", bad);
        end
        slave_clear(8'h00, 0, -1);
        send_cmd(1'b1, 3'd6, 8'h81, n);
        wait_rsp(n, lat, gaps);
        n_run++;
        if (lat !== 3 || rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_fresh: lat=%0d data=%h required 3/00", lat, rsp_data);
        end
        take_rsp();
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int n, lat, gaps, k, e, d;
        slave_clear(8'b1111_1101, 0, 2);
        send_cmd(1'b0, 3'd7, 8'h00, n);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(sl_beat == 2 && wb_stb) && k < 50);
        e = cyc_n;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (wb_cyc && k < 50);
        d = cyc_n;
        n_run++;
        if (d - e !== 4) begin
            n_fail++;
            $display("FAIL timeout_drop: cyc dropped after %0d required 4", d - e);
        end
        wait_rsp(n, lat, gaps);
        n_run++;
        if (rsp_err !== 1'b1 || rsp_data !== 8'h01) begin
            n_fail++;
            $display("FAIL timeout_rsp: err=%b data=%h required 1/01", rsp_err, rsp_data);
        end
        take_rsp();
        slave_clear(8'h00, 0, -1);
    endtask
`endif

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_we = 0;
        cmd_addr = 3'd0; cmd_data = 8'h00; rsp_ready = 0;
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_lfsr_master.md
# wb_lfsr_master

Wishbone pipelined-mode master that sits directly upstream of the `wb_lfsr` slave and turns simple byte-oriented commands into bus cycles. A command is either a single write beat (8-bit data to a 3-bit register address) or a packed read of `READ_BITS` consecutive 1-bit reads from one address, assembled into a byte response. It replaces raw pin-driven Wishbone strobing in `tt_um_lfsr` once a command front end (pin sampler or serial decoder) is attached.

## Interface
- `READ_BITS`, default 8: 1-bit read beats per read command. Legal range is 1..8.
- `TIMEOUT`, default 255: per-beat ack watchdog limit, in cycles. Used only with `WB_MASTER_TIMEOUT_EN`.

Ports (`name  direction  width  meaning`):
- `i_clk  in  1  single clock; all logic on rising edge`
- `i_reset_n  in  1  synchronous, active-low reset`
- `i_cmd_valid  in  1  command present`
- `o_cmd_ready  out  1  command accepted when valid&ready`
- `i_cmd_we  in  1  1=write, 0=packed read`
- `i_cmd_addr  in  3  register address`
- `i_cmd_data  in  8  write data`
- `o_rsp_valid  out  1  response present`
- `i_rsp_ready  in  1  response consumed when valid&ready`
- `o_rsp_data  out  8  packed read bits; 8'h00 for writes`
- `o_rsp_err  out  1  beat timed out`
- `o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone controls`
- `o_wb_addr  out  3  address`
- `o_wb_data  out  8  write data`
- `i_wb_stall, i_wb_ack  in  1 each  slave stall/ack`
- `i_wb_data  in  1  slave read bit`

## Operation
- FSM states are IDLE, REQ, WAIT_ACK and RESP.
- **IDLE**
  - `o_cmd_ready=1`.
  - On accept, capture we/addr/data, clear the bit counter and shift register, then go to REQ.
- **REQ**
  - `cyc=stb=1`; `we`, `addr` and `data` come from the captured command.
  - `stb` holds until `!i_wb_stall`.
  - When the strobe is accepted: if `i_wb_ack` is also high, the beat completes this cycle; otherwise go to WAIT_ACK.
- **WAIT_ACK**
  - `cyc=1`, `stb=0`; wait for `i_wb_ack`.
- **Beat completion**
  - On a read, `i_wb_data` is written into bit `count` of the shift register. The first bit goes to the LSB; unused upper bits stay 0.
  - If more beats remain (read, `count<READ_BITS-1`), increment `count` and go to REQ.
  - Otherwise drop `cyc` and go to RESP.
- **Cycle framing**
  - `cyc` stays high across all beats of one read command.
  - Only one beat is outstanding at a time.
- **RESP**
  - `o_rsp_valid=1`; data and err are held stable until `i_rsp_ready`, then go to IDLE.
- **Ignored inputs**
  - `i_wb_ack` is ignored in IDLE and RESP.
  - `i_wb_ack` is ignored in REQ while stalled.
- **Reset values**: all outputs 0, state IDLE, `count=0`. `o_cmd_ready` is 0 while in reset and 1 on the first cycle after reset releases.
- **Reset mid-operation**: the next edge returns to IDLE with `cyc`/`stb` low; any pending response is discarded.

## Timing
Cycle numbers are relative to the accept edge N.
- `stb` is first asserted at N+1.
- **Zero-stall slave with next-cycle ack**
  - Beat k: `stb` at N+1+2k, ack at N+2+2k.
  - Write: `o_rsp_valid` at N+3.
  - 8-bit read: `o_rsp_valid` at N+17.
- **Same-cycle ack**: saves one cycle per beat.
- **Back-to-back commands**: a new command can be accepted at the earliest one cycle after the response handshake.
- **Stall**: each stalled cycle adds one cycle.

## Configuration
- **`WB_MASTER_TIMEOUT_EN` defined**
  - A counter is cleared at each REQ entry and increments in REQ/WAIT_ACK.
  - On reaching `TIMEOUT`, drop `cyc`/`stb` and go to RESP with `o_rsp_err=1`.
  - `o_rsp_data` holds the bits collected so far.
- **Undefined**
  - No counter logic; the master waits indefinitely.
  - `o_rsp_err` is tied to 0.

## Structure
- Package `wb_lfsr_pkg` holds:
  - the state enum;
  - `WB_ADDR_W=3`, `WB_WDATA_W=8`, `WB_RDATA_W=1`;
  - the default `READ_BITS` and `TIMEOUT`.
- Sub-module `wb_timeout`:
  - loadable down-counter with an expiry flag;
  - instantiated only under `WB_MASTER_TIMEOUT_EN`.

## Test plan
- **Write**: write addr=3, data=8'hA5, zero-stall slave with ack one cycle after `stb`.
  - Exactly one `stb` cycle with `we=1`, addr=3, data=A5.
  - Response at N+3 with data=00, err=0.
- **Packed read**: read addr=1, slave bits 1,0,1,1,0,0,1,0 in beat order.
  - `o_rsp_data=8'h4D` at N+17.
  - `cyc` is continuous; 8 `stb` pulses.
- **Stall**: read with `i_wb_stall` high 3 cycles on beat 0.
  - `stb` and addr held stable throughout.
  - Response at N+20.
- **Backpressure**: hold `i_rsp_ready` low for 5 cycles.
  - `o_rsp_valid`, data and err stay stable.
  - `o_cmd_ready` stays 0 until the handshake.
- **Reset mid-operation**: assert `i_reset_n=0` during beat 4 of a read.
  - Next edge: `cyc=stb=0`, IDLE.
  - No response emitted.
  - A fresh command completes normally.
- **Timeout** (`WB_MASTER_TIMEOUT_EN`, `TIMEOUT`=4): slave never acks beat 2.
  - `cyc` drops 4 cycles after REQ entry.
  - Response has err=1 and data containing bits 0–1 only.
